uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (8-bit DataIn / DataInValid / DataInReady) between two byte-stream requesters: req0 (CPU memory-mapped UART TX path) and req1 (debug/echo source).
- Round-robin arbitration at packet granularity: an owner keeps the transmitter until it delivers a byte flagged last, or until its lock times out.
- One registered output stage between the arbiter and the UART. This keeps tx_data stable and decouples the requesters from UART back-pressure.

Parameters:
- DATA_WIDTH, 8, byte width on all data ports.
- LOCK_TIMEOUT, 1024, idle cycles a locked owner may hold the lock with valid low before forced release; 0 disables the timeout.
- TO_WIDTH, 11, timeout counter width; must satisfy 2^TO_WIDTH > LOCK_TIMEOUT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req0_data  in  8  requester 0 byte
- req0_valid  in  1  requester 0 byte valid
- req0_last  in  1  requester 0 byte ends packet
- req0_ready  out  1  requester 0 byte accepted this cycle when valid&ready
- req1_data  in  8  requester 1 byte
- req1_valid  in  1  requester 1 byte valid
- req1_last  in  1  requester 1 byte ends packet
- req1_ready  out  1  requester 1 byte accepted this cycle when valid&ready
- tx_data  out  8  to UART DataIn
- tx_valid  out  1  to UART DataInValid
- tx_ready  in  1  from UART DataInReady
- grant  out  2  one-hot current owner; 00 when idle
- lock_timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst_n low): state IDLE, grant=00, tx_valid=0, tx_data=0, req*_ready=0, lock_timeout=0, timeout counter=0, last_owner=1. With last_owner=1, req0 wins the first tie.
- States: IDLE, LOCK0, LOCK1. grant = {state==LOCK1, state==LOCK0}, registered.
- IDLE transitions (taken on the clock edge):
  - Only req0_valid → LOCK0.
  - Only req1_valid → LOCK1.
  - Both valid → the requester that is not last_owner.
  - Neither valid → stay in IDLE.
- IDLE accepts no byte. The first byte of a packet is accepted no earlier than the cycle after the request is sampled.
- Output-stage free condition: out_free = !tx_valid || tx_ready.
- Ready signals:
  - reqN_ready = (state==LOCKN) && out_free.
  - The non-owner's ready is 0.
  - Ready does not depend on reqN_valid.
- Accept (reqN_valid && reqN_ready): tx_data <= reqN_data and tx_valid <= 1 on the next edge. Latency is one cycle.
- Throughput: one byte per cycle while tx_ready is held high.
- Hold rule: if tx_valid && !tx_ready, both tx_data and tx_valid hold.
- Drain: if tx_ready and no accept, tx_valid <= 0.
- End of packet: accept with reqN_last=1 → IDLE and last_owner <= N.
- Re-arbitration: the earliest next accept from either requester is two cycles after the last-byte accept, through IDLE.
- Timeout counter:
  - Clears on every accept and in IDLE.
  - In LOCKN with reqN_valid=0, it increments.
  - On reaching LOCK_TIMEOUT-1 with valid still low: → IDLE, last_owner <= N, lock_timeout pulses for 1 cycle, counter clears.
  - Owner valid high while out_free=0 does not count toward timeout.
- Valid deassertion mid-packet is legal. The lock is kept until last or timeout.
- Byte in the output stage at timeout or end of packet: the buffered byte stays pending until tx_ready. A new owner's first accept waits for out_free.
- Reset mid-packet: the buffered byte is dropped, tx_valid=0 immediately, and the arbiter returns to IDLE.
- No combinational path from tx_ready to tx_valid or tx_data. The only combinational path from tx_ready is to reqN_ready.

Optional Feature:
- Macro: UART_ARB_STATS_EN.
- Defined: adds outputs stat0_bytes[15:0], stat1_bytes[15:0] (bytes accepted per requester) and stat_timeouts[7:0]. All counters saturate at all-ones, are cleared by rst_n, and update on the edge after the event.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then single packet: req0 sends 0x7a with last=1, tx_ready=1 → grant=01 one cycle after valid; tx_data=0x7a, tx_valid=1 one cycle after accept; return to IDLE, grant=00.
- Simultaneous requests: req0 and req1 valid in the same cycle after reset → req0 owns first. Its 3-byte packet 0x01,0x02,0x03(last) is sent intact, then req1's 0x7b(last) is sent. The UART sees 01,02,03,7b in that order.
- Back-pressure: tx_ready=0 for 20 cycles with 0x55 buffered → tx_data=0x55 stable, reqN_ready=0, counter not incremented; tx_ready=1 → byte drains, next byte accepted the same cycle.
- Timeout: req1 sends 0x10 (last=0) then drops valid → after LOCK_TIMEOUT cycles (1024; bench overrides LOCK_TIMEOUT=8), lock_timeout pulses once and pending req0 gains grant.
- Reset mid-packet: assert rst_n low with tx_valid=1 → tx_valid, grant and ready are 0 within the same cycle (async). After release, req0 wins the first tie.
- With UART_ARB_STATS_EN defined, run the second scenario plus the timeout scenario → stat0_bytes=3, stat1_bytes=2, stat_timeouts=1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter between two byte streams.
// Optional per-requester byte and timeout statistics are enabled with `define UART_ARB_STATS_EN.
module uart_tx_arbiter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned TO_WIDTH     = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_valid,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_valid,
  input  logic                  req1_last,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [1:0]            grant,
  output logic                  lock_timeout
`ifdef UART_ARB_STATS_EN
  ,
  output logic [15:0]           stat0_bytes,
  output logic [15:0]           stat1_bytes,
  output logic [7:0]            stat_timeouts
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(LOCK_TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic                    last_owner_q, last_owner_d;
  logic [TO_WIDTH-1:0]     to_cnt_q, to_cnt_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    lock_timeout_q, lock_timeout_d;

  logic out_free;
  logic acc0, acc1, accept;
  logic owner, own_valid, own_last;

  // tx_ready reaches only the ready outputs; everything driving the UART is registered.
  assign out_free   = !tx_valid_q || tx_ready;
  assign req0_ready = (state_q == LOCK0) && out_free;
  assign req1_ready = (state_q == LOCK1) && out_free;

  assign acc0      = req0_valid && req0_ready;
  assign acc1      = req1_valid && req1_ready;
  assign accept    = acc0 || acc1;
  assign owner     = (state_q == LOCK1);
  assign own_valid = owner ? req1_valid : req0_valid;
  assign own_last  = acc1 ? req1_last : req0_last;

  always_comb begin
    state_d        = state_q;
    last_owner_d   = last_owner_q;
    to_cnt_d       = to_cnt_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    lock_timeout_d = 1'b0;

    if (accept) begin
      tx_data_d  = acc1 ? req1_data : req0_data;
      tx_valid_d = 1'b1;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (req0_valid && (!req1_valid || last_owner_q)) begin
          state_d = LOCK0;
        end else if (req1_valid) begin
          state_d = LOCK1;
        end
      end
      LOCK0, LOCK1: begin
        if (accept) begin
          to_cnt_d = '0;
          if (own_last) begin
            state_d      = IDLE;
            last_owner_d = owner;
          end
        end else if (!own_valid && (LOCK_TIMEOUT != 0)) begin
          // A stalled owner with valid high is waiting on the UART, not idle.
          if (to_cnt_q == TO_LIMIT) begin
            state_d        = IDLE;
            last_owner_d   = owner;
            lock_timeout_d = 1'b1;
            to_cnt_d       = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_owner_q   <= 1'b1;
      to_cnt_q       <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      to_cnt_q       <= to_cnt_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign grant        = {state_q == LOCK1, state_q == LOCK0};
  assign lock_timeout = lock_timeout_q;

`ifdef UART_ARB_STATS_EN
  logic [15:0] stat0_q, stat0_d;
  logic [15:0] stat1_q, stat1_d;
  logic [7:0]  stat_to_q, stat_to_d;

  always_comb begin
    stat0_d   = stat0_q;
    stat1_d   = stat1_q;
    stat_to_d = stat_to_q;
    if (acc0 && (stat0_q != '1)) stat0_d = stat0_q + 16'd1;
    if (acc1 && (stat1_q != '1)) stat1_d = stat1_q + 16'd1;
    if (lock_timeout_d && (stat_to_q != '1)) stat_to_d = stat_to_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_q   <= '0;
      stat1_q   <= '0;
      stat_to_q <= '0;
    end else begin
      stat0_q   <= stat0_d;
      stat1_q   <= stat1_d;
      stat_to_q <= stat_to_d;
    end
  end

  assign stat0_bytes   = stat0_q;
  assign stat1_bytes   = stat1_q;
  assign stat_timeouts = stat_to_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int LT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req0_data, req1_data, tx_data;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic       tx_valid, tx_ready, lock_timeout;
  logic [1:0] grant;
`ifdef UART_ARB_STATS_EN
  logic [15:0] stat0_bytes, stat1_bytes;
  logic [7:0]  stat_timeouts;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DATA_WIDTH  (8),
    .LOCK_TIMEOUT(LT),
    .TO_WIDTH    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_data   (req0_data),
    .req0_valid  (req0_valid),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_data   (req1_data),
    .req1_valid  (req1_valid),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant       (grant),
    .lock_timeout(lock_timeout)
`ifdef UART_ARB_STATS_EN
    ,
    .stat0_bytes  (stat0_bytes),
    .stat1_bytes  (stat1_bytes),
    .stat_timeouts(stat_timeouts)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: owner -1 means nobody holds the transmitter.
  int         m_owner, m_last, m_idle;
  bit         m_bufv, m_pulse;
  logic [7:0] m_bufd;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [8:0] src0[$], src1[$];
  bit         rand_mode = 0;
  int         stall0 = 0, stall1 = 0;
  int         pulse_seen = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic m_reset();
    m_owner = -1;
    m_last  = 1;
    m_idle  = 0;
    m_bufv  = 0;
    m_bufd  = 8'h00;
    m_pulse = 0;
    exp_q.delete();
  endtask

  task automatic drive();
    bit g0, g1;
    g0 = src0.size() > 0;
    g1 = src1.size() > 0;
    if (rand_mode) begin
      if (stall0 > 0) begin stall0--; g0 = 0; end
      else if ($urandom_range(0, 99) < 3) stall0 = $urandom_range(4, 12);
      if (stall1 > 0) begin stall1--; g1 = 0; end
      else if ($urandom_range(0, 99) < 3) stall1 = $urandom_range(4, 12);
      if ($urandom_range(0, 3) == 0) g0 = 0;
      if ($urandom_range(0, 3) == 0) g1 = 0;
    end
    req0_valid = g0;
    req0_data  = g0 ? src0[0][7:0] : 8'($urandom);
    req0_last  = g0 ? src0[0][8]   : 1'($urandom);
    req1_valid = g1;
    req1_data  = g1 ? src1[0][7:0] : 8'($urandom);
    req1_last  = g1 ? src1[0][8]   : 1'($urandom);
  endtask

  // Compare at the falling edge, then advance the model to the next cycle.
  task automatic tick();
    bit free, r0, r1, a0, a1, ov, lst;
    logic [1:0] g;
    @(negedge clk);
    if (!rst_n) begin
      chk("grant", grant, 0);
      chk("tx_valid", tx_valid, 0);
      chk("tx_data", tx_data, 0);
      chk("req0_ready", req0_ready, 0);
      chk("req1_ready", req1_ready, 0);
      chk("lock_timeout", lock_timeout, 0);
      m_reset();
    end else begin
      free = !m_bufv || tx_ready;
      r0 = (m_owner == 0) && free;
      r1 = (m_owner == 1) && free;
      g  = {m_owner == 1, m_owner == 0};
      chk("grant", grant, g);
      chk("tx_valid", tx_valid, m_bufv);
      chk("tx_data", tx_data, m_bufd);
      chk("req0_ready", req0_ready, r0);
      chk("req1_ready", req1_ready, r1);
      chk("lock_timeout", lock_timeout, m_pulse);
      if (lock_timeout) pulse_seen++;
      if (tx_valid && tx_ready) begin
        obs_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL uart_order: got unexpected byte %0h expected none at %0t", tx_data, $time);
        end else begin
          chk("uart_order", tx_data, exp_q.pop_front());
        end
      end
      a0 = req0_valid && r0;
      a1 = req1_valid && r1;
      m_pulse = 0;
      if (a0 || a1) begin
        m_bufv = 1;
        m_bufd = a0 ? req0_data : req1_data;
        exp_q.push_back(m_bufd);
      end else if (tx_ready) begin
        m_bufv = 0;
      end
      if (a0) void'(src0.pop_front());
      if (a1) void'(src1.pop_front());
      if (m_owner < 0) begin
        m_idle = 0;
        if (req0_valid && req1_valid) m_owner = (m_last == 0) ? 1 : 0;
        else if (req0_valid) m_owner = 0;
        else if (req1_valid) m_owner = 1;
      end else begin
        ov  = (m_owner == 0) ? req0_valid : req1_valid;
        lst = a0 ? req0_last : req1_last;
        if (a0 || a1) begin
          m_idle = 0;
          if (lst) begin m_last = m_owner; m_owner = -1; end
        end else if (!ov) begin
          m_idle++;
          if (m_idle == LT) begin
            m_last = m_owner; m_owner = -1; m_pulse = 1; m_idle = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    drive();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src0.delete();
    src1.delete();
    stall0 = 0;
    stall1 = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_until_empty(string name, int budget);
    int n;
    n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || m_bufv) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s: got no drain within %0d cycles expected drain", name, budget);
    end
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got time limit expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s2_exp [4];
    int n;
    s2_exp[0] = 8'h01; s2_exp[1] = 8'h02; s2_exp[2] = 8'h03; s2_exp[3] = 8'h7b;
    rst_n = 1'b1;
    tx_ready = 1'b0;
    req0_valid = 0; req0_data = 0; req0_last = 0;
    req1_valid = 0; req1_data = 0; req1_last = 0;
    m_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_lock_timeout", lock_timeout, 0);
    @(posedge clk); #1;
    step();
    rst_n = 1'b1;

    // Single packet.
    src0.push_back({1'b1, 8'h7a});
    tx_ready = 1'b1;
    step();
    chk("s1_grant_lock", grant, 2'b01);
    step();
    chk("s1_grant_idle", grant, 2'b00);
    chk("s1_tx_valid", tx_valid, 1);
    chk("s1_tx_data", tx_data, 8'h7a);
    step();

    // Simultaneous requests after reset: req0 wins the first tie.
    do_reset();
    obs_q.delete();
    src0.push_back({1'b0, 8'h01});
    src0.push_back({1'b0, 8'h02});
    src0.push_back({1'b1, 8'h03});
    src1.push_back({1'b1, 8'h7b});
    step();
    chk("s2_first_owner", grant, 2'b01);
    run_until_empty("s2_drain", 40);
    chk("s2_count", obs_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < obs_q.size()) chk("s2_byte", obs_q[i], s2_exp[i]);

    // Timeout: req1 sends one non-last byte and goes quiet while req0 waits.
    src1.push_back({1'b0, 8'h10});
    step();
    chk("to_grant1", grant, 2'b10);
    src0.push_back({1'b1, 8'h20});
    step();
    chk("to_first_byte", tx_data, 8'h10);
    pulse_seen = 0;
    for (int k = 0; k < LT; k++) step();
    chk("to_pulse", lock_timeout, 1);
    chk("to_no_early_pulse", pulse_seen, 0);
    step();
    chk("to_pulse_once", pulse_seen, 1);
    chk("to_pulse_clear", lock_timeout, 0);
    chk("to_grant0", grant, 2'b01);
`ifdef UART_ARB_STATS_EN
    chk("stat0", stat0_bytes, 3);
    chk("stat1", stat1_bytes, 2);
    chk("stat_to", stat_timeouts, 1);
`endif
    run_until_empty("to_drain", 20);

    // Back-pressure with 0x55 buffered.
    do_reset();
    src0.push_back({1'b0, 8'h55});
    src0.push_back({1'b1, 8'h66});
    tx_ready = 1'b1;
    n = 0;
    while (!(m_bufv && m_bufd == 8'h55) && n < 10) begin step(); n++; end
    tx_ready = 1'b0;
    pulse_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("bp_data", tx_data, 8'h55);
      chk("bp_valid", tx_valid, 1);
      chk("bp_ready", req0_ready, 0);
    end
    chk("bp_no_timeout", pulse_seen, 0);
    tx_ready = 1'b1;
    drive();
    #1;
    chk("bp_ready_comb", req0_ready, 1);
    tick();
    chk("bp_next_byte", tx_data, 8'h66);
    step();

    // Reset mid-packet with a byte buffered.
    src0.push_back({1'b0, 8'ha1});
    src0.push_back({1'b1, 8'ha2});
    tx_ready = 1'b0;
    step();
    step();
    chk("mr_pre_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_tx_valid", tx_valid, 0);
    chk("mr_grant", grant, 0);
    chk("mr_ready0", req0_ready, 0);
    chk("mr_ready1", req1_ready, 0);
    src0.delete();
    src1.delete();
    step();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    src0.push_back({1'b1, 8'h31});
    src1.push_back({1'b1, 8'h32});
    step();
    chk("mr_tie_req0", grant, 2'b01);
    run_until_empty("mr_drain", 20);

    // Randomized traffic.
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (src0.size() == 0 && $urandom_range(0, 7) == 0) begin
        n = $urandom_range(1, 4);
        for (int b = 0; b < n; b++) src0.push_back({1'(b == n - 1), 8'($urandom)});
      end
      if (src1.size() == 0 && $urandom_range(0, 7) == 0) begin
        n = $urandom_range(1, 4);
        for (int b = 0; b < n; b++) src1.push_back({1'(b == n - 1), 8'($urandom)});
      end
      tx_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rand_mode = 0;
    tx_ready = 1'b1;
    run_until_empty("rand_drain", 300);
    chk("uart_all_delivered", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
